// File: rtl/rsa_job_sequencer.sv
// Byte-stream front end for an RSA modexp core: loads n, e, then data blocks
// MSB-first, starts the core, and streams the truncated result back out.
module rsa_job_sequencer #(
    parameter int KEY_BYTES = 32,
    parameter int OUT_BYTES = 31
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [7:0]             i_in_data,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    output logic [7:0]             o_out_data,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [8*KEY_BYTES-1:0] o_core_a,
    output logic [8*KEY_BYTES-1:0] o_core_e,
    output logic [8*KEY_BYTES-1:0] o_core_n,
    output logic                   o_core_start,
    input  logic [8*KEY_BYTES-1:0] i_core_result,
    input  logic                   i_core_finished,
    input  logic                   i_rekey,
    output logic                   o_busy,
    output logic [15:0]            o_block_count
);
    localparam int KW    = 8 * KEY_BYTES;
    localparam int OW    = 8 * OUT_BYTES;
    localparam int MAXB  = (KEY_BYTES > OUT_BYTES) ? KEY_BYTES : OUT_BYTES;
    localparam int CNT_W = $clog2(MAXB + 1);
    localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_BYTES - 1);
    localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_BYTES - 1);

    typedef enum logic [2:0] {
        S_GET_N, S_GET_E, S_GET_DATA, S_START, S_WAIT, S_SEND
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [KW-1:0]    n_q, n_d, e_q, e_d, a_q, a_d;
    logic [OW-1:0]    res_q, res_d;
    logic [15:0]      blk_q, blk_d;

    logic in_fire, out_fire, key_last, out_last, rekey_take;

    assign in_fire    = o_in_ready & i_in_valid;
    assign out_fire   = o_out_valid & i_out_ready;
    assign key_last   = (cnt_q == KEY_LAST);
    assign out_last   = (cnt_q == OUT_LAST);
    assign rekey_take = (state_q == S_GET_DATA) & i_rekey;

    // Result bits above the emitted width are intentionally discarded.
    generate
        if (OUT_BYTES < KEY_BYTES) begin : g_drop
            logic unused_hi;
            assign unused_hi = ^i_core_result[KW-1:OW];
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_GET_N;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_GET_N:    if (in_fire && key_last) state_d = S_GET_E;
            S_GET_E:    if (in_fire && key_last) state_d = S_GET_DATA;
            S_GET_DATA: begin
                if (i_rekey)                     state_d = S_GET_N;
                else if (in_fire && key_last)    state_d = S_START;
            end
            S_START:    state_d = S_WAIT;
            S_WAIT:     if (i_core_finished) state_d = S_SEND;
            S_SEND:     if (out_fire && out_last) state_d = S_GET_DATA;
            default:    state_d = S_GET_N;
        endcase
    end

    // Ready is gated by reset so nothing is accepted while reset is held.
    always_comb begin
        o_in_ready   = 1'b0;
        o_out_valid  = 1'b0;
        o_core_start = 1'b0;
        o_busy       = 1'b0;
        case (state_q)
            S_GET_N, S_GET_E: o_in_ready = i_rst_n;
            S_GET_DATA:       o_in_ready = i_rst_n & ~i_rekey;
            S_START: begin
                o_core_start = 1'b1;
                o_busy       = 1'b1;
            end
            S_WAIT:           o_busy = 1'b1;
            S_SEND: begin
                o_out_valid = 1'b1;
                o_busy      = 1'b1;
            end
            default: ;
        endcase
        o_out_data = o_out_valid ? res_q[OW-1 -: 8] : 8'h00;
    end

    always_comb begin
        cnt_d = cnt_q;
        n_d   = n_q;
        e_d   = e_q;
        a_d   = a_q;
        res_d = res_q;
        blk_d = blk_q;
        if (rekey_take) begin
            cnt_d = '0;
        end else if (in_fire) begin
            cnt_d = key_last ? '0 : cnt_q + CNT_W'(1);
            case (state_q)
                S_GET_N:    n_d = {n_q[KW-9:0], i_in_data};
                S_GET_E:    e_d = {e_q[KW-9:0], i_in_data};
                S_GET_DATA: a_d = {a_q[KW-9:0], i_in_data};
                default: ;
            endcase
        end else if (out_fire) begin
            cnt_d = out_last ? '0 : cnt_q + CNT_W'(1);
            res_d = {res_q[OW-9:0], 8'h00};
            if (out_last) blk_d = blk_q + 16'd1;
        end
        if (state_q == S_WAIT && i_core_finished) begin
            res_d = i_core_result[OW-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            n_q   <= '0;
            e_q   <= '0;
            a_q   <= '0;
            res_q <= '0;
            blk_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            n_q   <= n_d;
            e_q   <= e_d;
            a_q   <= a_d;
            res_q <= res_d;
            blk_q <= blk_d;
        end
    end

    assign o_core_a      = a_q;
    assign o_core_e      = e_q;
    assign o_core_n      = n_q;
    assign o_block_count = blk_q;

endmodule
